rom_refill_arbiter: RTL and testbench
=====================================

ROM_REFILL_ARBITER -- requirements
Module: rom_refill_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, ROM word / cache word width in bits.
REQ-002 Parameter: ADDR_W, 8, ROM address width; line size fixed at 8 words (3-bit offset).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 sync_reset  input  1  synchronous, active-high reset.
REQ-005 req  input  2  refill request per requester (bit 0 = requester 0); held high until its done pulse.
REQ-006 req_addr0, req_addr1  input  ADDR_W each  missing-word address of requester 0/1.
REQ-007 rom_address  output  ADDR_W  ROM read address.
REQ-008 rom_q  input  DATA_W  ROM read data, valid one cycle after rom_address.
REQ-009 gnt  output  2  one-hot owner of the current burst; 0 when idle.
REQ-010 wr_en  output  1  cache line write strobe to the owner.
REQ-011 wr_offset  output  3  word offset within the line for the current write.
REQ-012 wr_data  output  DATA_W  registered copy of rom_q.
REQ-013 done  output  2  one-cycle pulse to the owner after its eighth write.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, BURST, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE: any req bit high -> latch winner and its req_addr, set gnt, go to BURST next cycle.
REQ-017 Arbitration round-robin: last_owner reset to 1, so requester 0 wins first tie; on tie the requester that is not last_owner wins; single request wins immediately.
REQ-018 BURST: 8 consecutive cycles, rom_address = {line_base[ADDR_W-1:3], issue_offset}; issue_offset increments mod 8 each cycle.
REQ-019 Each issued address produces wr_en=1 exactly one cycle later, with wr_offset = that offset and wr_data = rom_q.
REQ-020 After the eighth address, go to DRAIN for one cycle (last write), then DONE.
REQ-021 DONE: done[owner]=1 for one cycle, gnt cleared, last_owner updated, return to IDLE; re-arbitration no earlier than the following cycle.
REQ-022 Total latency: grant cycle G; addresses G+1..G+8; writes G+2..G+9; done at G+10; next grant at G+11 at the earliest.
REQ-023 req deassert mid-burst is ignored; burst always completes all 8 words.
REQ-024 req changes and req_addr changes after the grant cycle do not affect the current burst.
REQ-025 rom_address = 0, wr_en = 0, wr_offset = 0 outside BURST/DRAIN write cycles.
REQ-026 Offset arithmetic is 3-bit wrap-around; line base bits never change within a burst.

Reset
REQ-027 sync_reset high at a posedge: next cycle state=IDLE, gnt=0, done=0, wr_en=0, wr_offset=0, wr_data=0, rom_address=0, busy=0, last_owner=1.
REQ-028 Reset mid-burst aborts with no further writes and no done pulse; requesters re-request afterwards.

Configuration
REQ-029 Macro REFILL_CRITICAL_WORD_FIRST_EN defined: burst starts at the latched req_addr[2:0] and wraps mod 8 through all 8 offsets.
REQ-030 Macro undefined: burst always starts at offset 0 (req_addr[2:0] ignored), ascending order 0..7.

Structure
REQ-031 Package refill_pkg holds the FSM state enum, LINE_WORDS=8 and OFFSET_W=3 constants.
REQ-032 One sub-module, rr_arbiter2: combinational two-way round-robin pick from req and last_owner; all FSM, address and write logic stays in the top.

Verification
REQ-033 Reset, then req=01, req_addr0=8'h35 -> gnt=01; rom_address 8'h30..8'h37 (macro off) or 8'h35,36,37,30..34 (macro on); 8 writes; done=01 at G+10.
REQ-034 req=11 from reset -> requester 0 served first, requester 1 granted at G+11; then both again -> requester 0 after requester 1 (alternation).
REQ-035 Requester 0 drops req after 3 addresses -> all 8 writes and done=01 still occur.
REQ-036 sync_reset asserted in cycle G+4 -> next cycle all outputs 0, no done; new req=10 afterwards granted normally.
REQ-037 ROM model returns word=address; check wr_data equals line base | wr_offset on every write, including the wrap from 7 to 0 with macro on and req_addr1=8'hF7.

Source files
------------

// File: rtl/refill_pkg.sv
// Shared constants and FSM state encoding for the ROM line-refill arbiter.
package refill_pkg;

  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the
// requester that did not own the previous burst wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick,
  output logic       winner
);

  always_comb begin
    pick   = 2'b00;
    winner = 1'b0;
    case (req)
      2'b01: begin
        pick   = 2'b01;
        winner = 1'b0;
      end
      2'b10: begin
        pick   = 2'b10;
        winner = 1'b1;
      end
      2'b11: begin
        winner = ~last_owner;
        pick   = last_owner ? 2'b01 : 2'b10;
      end
      default: begin
        pick   = 2'b00;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rom_refill_arbiter.sv
// Arbitrates two cache-line refill requesters onto one ROM and streams an
// 8-word line back to the owner. Define REFILL_CRITICAL_WORD_FIRST_EN to start each burst at the missing word.
//
// state | meaning
// IDLE  | no burst; arbitrate and latch winner, line base and start offset
// BURST | issue 8 consecutive ROM addresses, one per cycle
// DRAIN | last ROM word lands in wr_data
// DONE  | done pulse to owner, release grant, remember owner for round-robin
module rom_refill_arbiter
  import refill_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [1:0]        gnt,
  output logic              wr_en,
  output logic [2:0]        wr_offset,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        done,
  output logic              busy
);

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam logic CWF_EN = 1'b1;
`else
  localparam logic CWF_EN = 1'b0;
`endif

  localparam logic [OFFSET_W-1:0] LAST_COUNT = OFFSET_W'(LINE_WORDS - 1);

  refill_state_e              state;
  logic                       owner;
  logic                       last_owner;
  logic [ADDR_W-OFFSET_W-1:0] line_base;
  logic [OFFSET_W-1:0]        issue_offset;
  logic [OFFSET_W-1:0]        words_left;

  logic [1:0]          pick;
  logic                winner;
  logic [ADDR_W-1:0]   win_addr;
  logic [OFFSET_W-1:0] start_offset;

  rr_arbiter2 u_arb (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .winner     (winner)
  );

  assign win_addr     = winner ? req_addr1 : req_addr0;
  assign start_offset = CWF_EN ? win_addr[OFFSET_W-1:0] : '0;

  // words_left is a down-counter; its terminal count marks the eighth address
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state        <= ST_IDLE;
      gnt          <= 2'b00;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      line_base    <= '0;
      issue_offset <= '0;
      words_left   <= '0;
      done         <= 2'b00;
      wr_en        <= 1'b0;
      wr_offset    <= '0;
      wr_data      <= '0;
    end else begin
      done      <= 2'b00;
      wr_en     <= (state == ST_BURST);
      wr_offset <= (state == ST_BURST) ? issue_offset : '0;
      wr_data   <= (state == ST_BURST) ? rom_q : '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt          <= pick;
            owner        <= winner;
            line_base    <= win_addr[ADDR_W-1:OFFSET_W];
            issue_offset <= start_offset;
            words_left   <= LAST_COUNT;
            state        <= ST_BURST;
          end
        end
        ST_BURST: begin
          issue_offset <= issue_offset + 1'b1;
          words_left   <= words_left - 1'b1;
          if (words_left == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          done  <= gnt;
          state <= ST_DONE;
        end
        ST_DONE: begin
          gnt        <= 2'b00;
          last_owner <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rom_address = (state == ST_BURST) ? {line_base, issue_offset} : '0;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_rom_refill_arbiter.sv
// Directed bench for rom_refill_arbiter: ROM returns word = address, expected
// line writes are queued at request time and popped as wr_en strobes arrive.
module tb_rom_refill_arbiter;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [1:0]  req;
  logic [7:0]  req_addr0, req_addr1;
  logic [7:0]  rom_address;
  logic [15:0] rom_q;
  logic [1:0]  gnt;
  logic        wr_en;
  logic [2:0]  wr_offset;
  logic [15:0] wr_data;
  logic [1:0]  done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  off;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];

  always #5 clk = ~clk;

  assign rom_q = {8'h00, rom_address};

  rom_refill_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .req         (req),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .gnt         (gnt),
    .wr_en       (wr_en),
    .wr_offset   (wr_offset),
    .wr_data     (wr_data),
    .done        (done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] start_off(input logic [7:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    return a[2:0];
`else
    return 3'd0;
`endif
  endfunction

  task automatic push_line(input logic [7:0] a);
    wr_t w;
    for (int k = 0; k < 8; k++) begin
      w.off  = start_off(a) + 3'(k);
      w.data = {8'h00, a[7:3], w.off};
      sb.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (wr_en === 1'b1) begin
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_offset", 32'(wr_offset), 32'(e.off));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end else begin
      chk("wr_offset_idle", 32'(wr_offset), 32'd0);
    end
  end

  // Called on the negedge of the grant cycle G (req already driven).
  task automatic expect_burst(input logic own, input logic [7:0] a, input int drop_at);
    logic [1:0] g;
    logic [2:0] off;
    g   = own ? 2'b10 : 2'b01;
    off = start_off(a);
    push_line(a);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("burst_gnt", 32'(gnt), 32'(g));
      chk("burst_busy", 32'(busy), 32'd1);
      chk("burst_rom_address", 32'(rom_address), 32'({a[7:3], 3'(off + 3'(k - 1))}));
      chk("burst_done_early", 32'(done), 32'd0);
      if (k == 2) begin
        if (own) req_addr1 = ~a;
        else     req_addr0 = ~a;
      end
      if (k == drop_at) req[own] = 1'b0;
    end
    @(negedge clk);
    chk("drain_rom_address", 32'(rom_address), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(g));
    chk("done_busy", 32'(busy), 32'd1);
    req[own] = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rom_address", 32'(rom_address), 32'd0);
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    req        = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sync_reset = 1'b0;
  endtask

  initial begin
    sync_reset = 1'b1;
    req        = 2'b00;
    req_addr0  = 8'h00;
    req_addr1  = 8'h00;
    do_reset();

    // single requester 0
    req_addr0 = 8'h35;
    req       = 2'b01;
    expect_burst(1'b0, 8'h35, 0);

    // tie from reset: 0 first, then 1, then alternation continues
    do_reset();
    req_addr0 = 8'h12;
    req_addr1 = 8'hA9;
    req       = 2'b11;
    expect_burst(1'b0, 8'h12, 0);
    expect_burst(1'b1, 8'hA9, 0);
    req_addr0 = 8'h44;
    req_addr1 = 8'h5B;
    req       = 2'b11;
    expect_burst(1'b0, 8'h44, 0);
    expect_burst(1'b1, 8'h5B, 0);

    // requester drops req after three addresses
    req_addr0 = 8'h6E;
    req       = 2'b01;
    expect_burst(1'b0, 8'h6E, 3);

    // reset in G+4 aborts the burst
    req_addr1 = 8'hC3;
    req       = 2'b10;
    push_line(8'hC3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("abort_rom_address", 32'(rom_address),
          32'({5'(8'hC3 >> 3), 3'(start_off(8'hC3) + 3'(k - 1))}));
    end
    sync_reset = 1'b1;
    req        = 2'b00;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_data", 32'(wr_data), 32'd0);
    chk("abort_rom_address", 32'(rom_address), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_writes_left", 32'(sb.size()), 32'd5);
    sb.delete();
    sync_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
    end

    // re-request after abort; line F0 exercises the 7 -> 0 wrap
    req_addr1 = 8'hF7;
    req       = 2'b10;
    expect_burst(1'b1, 8'hF7, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
